// File: rtl/alu16_sequencer_if.sv
// Request, ALU and response bundle for alu16_sequencer.
// slave is the sequencer's view; master is the view of whatever drives it.
interface alu16_sequencer_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [1:0]  req_cmd_i;
   logic [15:0] req_a_i;
   logic [15:0] req_b_i;
   logic [3:0]  req_flags_i;

   logic        alu_valid_o;
   logic        alu_sub_o;
   logic        alu_cin_o;
   logic [7:0]  alu_a_o;
   logic [7:0]  alu_b_o;
   logic [7:0]  alu_result_i;
   logic        alu_cout_i;
   logic        alu_hout_i;

   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [15:0] rsp_result_o;
   logic [3:0]  rsp_flags_o;

   modport slave (
      input  req_valid_i, req_cmd_i, req_a_i, req_b_i, req_flags_i,
      input  alu_result_i, alu_cout_i, alu_hout_i, rsp_ready_i,
      output req_ready_o, alu_valid_o, alu_sub_o, alu_cin_o, alu_a_o, alu_b_o,
      output rsp_valid_o, rsp_result_o, rsp_flags_o
   );

   modport master (
      output req_valid_i, req_cmd_i, req_a_i, req_b_i, req_flags_i,
      output alu_result_i, alu_cout_i, alu_hout_i, rsp_ready_i,
      input  req_ready_o, alu_valid_o, alu_sub_o, alu_cin_o, alu_a_o, alu_b_o,
      input  rsp_valid_o, rsp_result_o, rsp_flags_o
   );
endinterface

// File: rtl/alu16_sequencer.sv
// Runs 16-bit ADD16/INC16/DEC16/ADD_SP_E8 as two chained byte ops on an 8-bit ALU.
// Define ALU_SEQ_PERF_CNT_EN to add perf_count_o (saturating count of completed responses).
//
// state    | meaning
// IDLE     | ready for a request, nothing in flight
// LO_ISSUE | low-byte op presented to the ALU
// LO_WAIT  | waiting out ALU latency, low result sampled on the last cycle
// HI_ISSUE | high-byte op presented, carry/borrow from the low byte chained in
// HI_WAIT  | waiting out ALU latency, high result sampled on the last cycle
// RESP     | result and flags held until the consumer takes them
module alu16_sequencer #(
   parameter int ALU_LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef ALU_SEQ_PERF_CNT_EN
   output logic [15:0]        perf_count_o,
`endif
   alu16_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO_ISSUE,
      S_LO_WAIT,
      S_HI_ISSUE,
      S_HI_WAIT,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      CMD_ADD16  = 2'b00,
      CMD_INC16  = 2'b01,
      CMD_DEC16  = 2'b10,
      CMD_ADD_SP = 2'b11
   } cmd_t;

   // Wait states last ALU_LATENCY cycles; the down-counter hits zero on the sample cycle.
   localparam logic [1:0] WAIT_LOAD = 2'(ALU_LATENCY - 1);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   cmd_t        cmd_q, cmd_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [3:0]  flags_q, flags_d;
   logic [7:0]  res_lo_q, res_lo_d;
   logic        c_lo_q, c_lo_d;
   logic        h_lo_q, h_lo_d;

   logic        req_ready_q, req_ready_d;
   logic        alu_valid_q, alu_valid_d;
   logic        alu_sub_q, alu_sub_d;
   logic        alu_cin_q, alu_cin_d;
   logic [7:0]  alu_a_q, alu_a_d;
   logic [7:0]  alu_b_q, alu_b_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_result_q, rsp_result_d;
   logic [3:0]  rsp_flags_q, rsp_flags_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cmd_d        = cmd_q;
      a_d          = a_q;
      b_d          = b_q;
      flags_d      = flags_q;
      res_lo_d     = res_lo_q;
      c_lo_d       = c_lo_q;
      h_lo_d       = h_lo_q;
      req_ready_d  = req_ready_q;
      alu_valid_d  = 1'b0;
      alu_sub_d    = 1'b0;
      alu_cin_d    = 1'b0;
      alu_a_d      = 8'h00;
      alu_b_d      = 8'h00;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid_i) begin
               cmd_d       = cmd_t'(bus.req_cmd_i);
               a_d         = bus.req_a_i;
               b_d         = bus.req_b_i;
               flags_d     = bus.req_flags_i;
               req_ready_d = 1'b0;
               state_d     = S_LO_ISSUE;
               alu_valid_d = 1'b1;
               alu_a_d     = bus.req_a_i[7:0];
               case (cmd_t'(bus.req_cmd_i))
                  CMD_ADD16:  alu_b_d = bus.req_b_i[7:0];
                  CMD_INC16:  alu_b_d = 8'h01;
                  CMD_DEC16: begin
                     alu_b_d   = 8'h01;
                     alu_sub_d = 1'b1;
                  end
                  default:    alu_b_d = bus.req_b_i[7:0];
               endcase
            end
         end

         S_LO_ISSUE: begin
            cnt_d   = WAIT_LOAD;
            state_d = S_LO_WAIT;
         end

         S_LO_WAIT: begin
            if (cnt_q == 2'd0) begin
               res_lo_d    = bus.alu_result_i;
               c_lo_d      = bus.alu_cout_i;
               h_lo_d      = bus.alu_hout_i;
               state_d     = S_HI_ISSUE;
               alu_valid_d = 1'b1;
               alu_a_d     = a_q[15:8];
               alu_cin_d   = bus.alu_cout_i;
               case (cmd_q)
                  CMD_ADD16:  alu_b_d = b_q[15:8];
                  CMD_INC16:  alu_b_d = 8'h00;
                  CMD_DEC16: begin
                     alu_b_d   = 8'h00;
                     alu_sub_d = 1'b1;
                  end
                  default:    alu_b_d = {8{b_q[7]}};
               endcase
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end

         S_HI_ISSUE: begin
            cnt_d   = WAIT_LOAD;
            state_d = S_HI_WAIT;
         end

         S_HI_WAIT: begin
            if (cnt_q == 2'd0) begin
               rsp_result_d = {bus.alu_result_i, res_lo_q};
               rsp_valid_d  = 1'b1;
               state_d      = S_RESP;
               // ADD16 keeps the incoming Z; ADD_SP_E8 takes H/C from the low byte.
               case (cmd_q)
                  CMD_ADD16:  rsp_flags_d = {flags_q[3], 1'b0, bus.alu_hout_i, bus.alu_cout_i};
                  CMD_INC16,
                  CMD_DEC16:  rsp_flags_d = flags_q;
                  default:    rsp_flags_d = {2'b00, h_lo_q, c_lo_q};
               endcase
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end

         S_RESP: begin
            if (bus.rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 2'd0;
         cmd_q        <= CMD_ADD16;
         a_q          <= 16'h0000;
         b_q          <= 16'h0000;
         flags_q      <= 4'h0;
         res_lo_q     <= 8'h00;
         c_lo_q       <= 1'b0;
         h_lo_q       <= 1'b0;
         req_ready_q  <= 1'b1;
         alu_valid_q  <= 1'b0;
         alu_sub_q    <= 1'b0;
         alu_cin_q    <= 1'b0;
         alu_a_q      <= 8'h00;
         alu_b_q      <= 8'h00;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= 16'h0000;
         rsp_flags_q  <= 4'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cmd_q        <= cmd_d;
         a_q          <= a_d;
         b_q          <= b_d;
         flags_q      <= flags_d;
         res_lo_q     <= res_lo_d;
         c_lo_q       <= c_lo_d;
         h_lo_q       <= h_lo_d;
         req_ready_q  <= req_ready_d;
         alu_valid_q  <= alu_valid_d;
         alu_sub_q    <= alu_sub_d;
         alu_cin_q    <= alu_cin_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
      end
   end

   assign bus.req_ready_o  = req_ready_q;
   assign bus.alu_valid_o  = alu_valid_q;
   assign bus.alu_sub_o    = alu_sub_q;
   assign bus.alu_cin_o    = alu_cin_q;
   assign bus.alu_a_o      = alu_a_q;
   assign bus.alu_b_o      = alu_b_q;
   assign bus.rsp_valid_o  = rsp_valid_q;
   assign bus.rsp_result_o = rsp_result_q;
   assign bus.rsp_flags_o  = rsp_flags_q;

`ifdef ALU_SEQ_PERF_CNT_EN
   logic [15:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (state_q == S_RESP && bus.rsp_ready_i && perf_q != 16'hFFFF) begin
         perf_d = perf_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= 16'h0000;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_count_o = perf_q;
`endif

endmodule

// File: tb/tb_alu16_sequencer.sv
// Bench for alu16_sequencer: two instances (ALU latency 1 and 3) each driven by a
// behavioural 8-bit registered ALU, checked against a plain-arithmetic 16-bit model.
module tb_alu16_sequencer;

   localparam int L1 = 1;
   localparam int L3 = 3;

   logic clk;
   logic rst_n;

   alu16_sequencer_if if1 ();
   alu16_sequencer_if if3 ();

`ifdef ALU_SEQ_PERF_CNT_EN
   logic [15:0] perf1, perf3;
`endif

   alu16_sequencer #(.ALU_LATENCY(L1)) dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
`ifdef ALU_SEQ_PERF_CNT_EN
      .perf_count_o (perf1),
`endif
      .bus          (if1.slave)
   );

   alu16_sequencer #(.ALU_LATENCY(L3)) dut3 (
      .clk          (clk),
      .rst_n        (rst_n),
`ifdef ALU_SEQ_PERF_CNT_EN
      .perf_count_o (perf3),
`endif
      .bus          (if3.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Byte ALU: returns {hout, cout, result}.
   function automatic logic [9:0] alu_calc(input logic sub, input logic cin,
                                           input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      logic [4:0] hs;
      if (!sub) begin
         s  = 9'(a) + 9'(b) + 9'(cin);
         hs = 5'(a[3:0]) + 5'(b[3:0]) + 5'(cin);
      end else begin
         s  = 9'(a) - 9'(b) - 9'(cin);
         hs = 5'(a[3:0]) - 5'(b[3:0]) - 5'(cin);
      end
      return {hs[4], s[8], s[7:0]};
   endfunction

   // 16-bit reference: returns {result, flags ZNHC}.
   function automatic logic [19:0] ref_op(input logic [1:0] c, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] f);
      int ai, bi, e, sum;
      logic h, cy;
      logic [15:0] r;
      logic [3:0] fl;
      ai = int'(a);
      bi = int'(b);
      case (c)
         2'd0: begin
            sum = ai + bi;
            r   = 16'(sum);
            h   = ((ai & 'hFFF) + (bi & 'hFFF)) > 'hFFF;
            cy  = sum > 'hFFFF;
            fl  = {f[3], 1'b0, h, cy};
         end
         2'd1: begin
            r  = 16'(ai + 1);
            fl = f;
         end
         2'd2: begin
            r  = 16'(ai - 1);
            fl = f;
         end
         default: begin
            e  = int'($signed(b[7:0]));
            r  = 16'(ai + e);
            h  = ((ai & 'hF) + (bi & 'hF)) > 'hF;
            cy = ((ai & 'hFF) + (bi & 'hFF)) > 'hFF;
            fl = {2'b00, h, cy};
         end
      endcase
      return {r, fl};
   endfunction

   typedef struct {
      int         due;
      logic [7:0] r;
      logic       co;
      logic       ho;
   } alu_ent_t;

   alu_ent_t q1[$];
   alu_ent_t q3[$];
   int cyc1 = 0;
   int cyc3 = 0;

   // ALU models: result of an issue in cycle t is presented in cycle t+L, junk otherwise.
   initial begin
      logic [9:0] calc;
      forever begin
         @(posedge clk); #1;
         cyc1++;
         if1.alu_result_i = 8'($urandom);
         if1.alu_cout_i   = 1'($urandom);
         if1.alu_hout_i   = 1'($urandom);
         foreach (q1[i]) begin
            if (q1[i].due == cyc1) begin
               if1.alu_result_i = q1[i].r;
               if1.alu_cout_i   = q1[i].co;
               if1.alu_hout_i   = q1[i].ho;
            end
         end
         while (q1.size() > 0 && q1[0].due <= cyc1) q1.delete(0);
         @(negedge clk);
         if (if1.alu_valid_o === 1'b1) begin
            calc = alu_calc(if1.alu_sub_o, if1.alu_cin_o, if1.alu_a_o, if1.alu_b_o);
            q1.push_back('{cyc1 + L1, calc[7:0], calc[8], calc[9]});
         end
      end
   end

   initial begin
      logic [9:0] calc;
      forever begin
         @(posedge clk); #1;
         cyc3++;
         if3.alu_result_i = 8'($urandom);
         if3.alu_cout_i   = 1'($urandom);
         if3.alu_hout_i   = 1'($urandom);
         foreach (q3[i]) begin
            if (q3[i].due == cyc3) begin
               if3.alu_result_i = q3[i].r;
               if3.alu_cout_i   = q3[i].co;
               if3.alu_hout_i   = q3[i].ho;
            end
         end
         while (q3.size() > 0 && q3[0].due <= cyc3) q3.delete(0);
         @(negedge clk);
         if (if3.alu_valid_o === 1'b1) begin
            calc = alu_calc(if3.alu_sub_o, if3.alu_cin_o, if3.alu_a_o, if3.alu_b_o);
            q3.push_back('{cyc3 + L3, calc[7:0], calc[8], calc[9]});
         end
      end
   end

   logic        s_req_ready, s_alu_valid, s_alu_sub, s_alu_cin, s_rsp_valid;
   logic [7:0]  s_alu_a, s_alu_b;
   logic [15:0] s_rsp_result;
   logic [3:0]  s_rsp_flags;

   logic        pl_sub[2];
   logic        pl_cin[2];
   logic [7:0]  pl_a[2];
   logic [7:0]  pl_b[2];

   task automatic snap(input int w);
      if (w == 1) begin
         s_req_ready  = if1.req_ready_o;  s_alu_valid = if1.alu_valid_o;
         s_alu_sub    = if1.alu_sub_o;    s_alu_cin   = if1.alu_cin_o;
         s_alu_a      = if1.alu_a_o;      s_alu_b     = if1.alu_b_o;
         s_rsp_valid  = if1.rsp_valid_o;  s_rsp_result = if1.rsp_result_o;
         s_rsp_flags  = if1.rsp_flags_o;
      end else begin
         s_req_ready  = if3.req_ready_o;  s_alu_valid = if3.alu_valid_o;
         s_alu_sub    = if3.alu_sub_o;    s_alu_cin   = if3.alu_cin_o;
         s_alu_a      = if3.alu_a_o;      s_alu_b     = if3.alu_b_o;
         s_rsp_valid  = if3.rsp_valid_o;  s_rsp_result = if3.rsp_result_o;
         s_rsp_flags  = if3.rsp_flags_o;
      end
   endtask

   task automatic drive_req(input int w, input logic v, input logic [1:0] c,
                            input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
      if (w == 1) begin
         if1.req_valid_i = v; if1.req_cmd_i = c; if1.req_a_i = a; if1.req_b_i = b; if1.req_flags_i = f;
      end else begin
         if3.req_valid_i = v; if3.req_cmd_i = c; if3.req_a_i = a; if3.req_b_i = b; if3.req_flags_i = f;
      end
   endtask

   // Called just after a rising edge; returns just after the edge following the response cycle.
   task automatic run_op(input int w, input logic [1:0] c, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] f,
                         output logic [15:0] res, output logic [3:0] fl,
                         output int lat, output int pulses);
      drive_req(w, 1'b1, c, a, b, f);
      @(negedge clk); snap(w);
      check("req_ready_idle", 32'(s_req_ready), 32'd1);
      @(posedge clk); #1;
      drive_req(w, 1'b0, 2'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
      lat = 0; pulses = 0; res = '0; fl = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk); snap(w);
         if (s_alu_valid) begin
            if (pulses < 2) begin
               pl_sub[pulses] = s_alu_sub; pl_cin[pulses] = s_alu_cin;
               pl_a[pulses]   = s_alu_a;   pl_b[pulses]   = s_alu_b;
            end
            pulses++;
         end
         if (s_rsp_valid) begin
            lat = k; res = s_rsp_result; fl = s_rsp_flags;
            break;
         end
         @(posedge clk); #1;
      end
      check("rsp_timeout", 32'(lat != 0), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic rand_op(input int w, input int exp_lat);
      logic [1:0]  c;
      logic [15:0] a, b, r;
      logic [3:0]  f, fl;
      logic [19:0] e;
      int lat, p;
      c = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b = 16'($urandom);
      f = 4'($urandom);
      e = ref_op(c, a, b, f);
      run_op(w, c, a, b, f, r, fl, lat, p);
      check("rand_result", 32'(r), 32'(e[19:4]));
      check("rand_flags", 32'(fl), 32'(e[3:0]));
      check("rand_latency", 32'(lat), 32'(exp_lat));
      check("rand_pulses", 32'(p), 32'd2);
   endtask

   typedef struct {
      logic [1:0]  cmd;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  f;
      logic [15:0] exp_r;
      logic [3:0]  exp_f;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [15:0] r;
      logic [3:0]  fl;
      int lat, p;

      vecs[0] = '{2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010};
      vecs[1] = '{2'd0, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011};
      vecs[2] = '{2'd1, 16'hFFFF, 16'h5A5A, 4'b1010, 16'h0000, 4'b1010};
      vecs[3] = '{2'd2, 16'h0000, 16'hA5A5, 4'b0101, 16'hFFFF, 4'b0101};
      vecs[4] = '{2'd3, 16'hFFF8, 16'h0008, 4'b1100, 16'h0000, 4'b0011};
      vecs[5] = '{2'd3, 16'h1000, 16'h00FF, 4'b1111, 16'h0FFF, 4'b0000};
      vecs[6] = '{2'd0, 16'h8000, 16'h8000, 4'b0000, 16'h0000, 4'b0001};
      vecs[7] = '{2'd2, 16'h1234, 16'hFFFF, 4'b1000, 16'h1233, 4'b1000};

      rst_n = 1'b0;
      drive_req(1, 1'b0, 2'd0, 16'h0, 16'h0, 4'h0);
      drive_req(3, 1'b0, 2'd0, 16'h0, 16'h0, 4'h0);
      if1.rsp_ready_i = 1'b1;
      if3.rsp_ready_i = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk); snap(1);
      check("rst_req_ready", 32'(s_req_ready), 32'd1);
      check("rst_alu_valid", 32'(s_alu_valid), 32'd0);
      check("rst_rsp_valid", 32'(s_rsp_valid), 32'd0);
      check("rst_rsp_result", 32'(s_rsp_result), 32'd0);
      check("rst_rsp_flags", 32'(s_rsp_flags), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_op(1, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].f, r, fl, lat, p);
         check("tbl_result", 32'(r), 32'(vecs[i].exp_r));
         check("tbl_flags", 32'(fl), 32'(vecs[i].exp_f));
         check("tbl_latency", 32'(lat), 32'd5);
         check("tbl_pulses", 32'(p), 32'd2);
         if (i == 0) begin
            check("add_lo_sub", 32'(pl_sub[0]), 32'd0);
            check("add_lo_cin", 32'(pl_cin[0]), 32'd0);
            check("add_lo_a", 32'(pl_a[0]), 32'hFF);
            check("add_lo_b", 32'(pl_b[0]), 32'h01);
            check("add_hi_sub", 32'(pl_sub[1]), 32'd0);
            check("add_hi_cin", 32'(pl_cin[1]), 32'd1);
            check("add_hi_a", 32'(pl_a[1]), 32'h0F);
            check("add_hi_b", 32'(pl_b[1]), 32'h00);
         end
         if (i == 3) begin
            check("dec_lo_sub", 32'(pl_sub[0]), 32'd1);
            check("dec_lo_b", 32'(pl_b[0]), 32'h01);
            check("dec_hi_sub", 32'(pl_sub[1]), 32'd1);
            check("dec_hi_cin", 32'(pl_cin[1]), 32'd1);
            check("dec_hi_b", 32'(pl_b[1]), 32'h00);
         end
         if (i == 5) check("sp_hi_b", 32'(pl_b[1]), 32'hFF);
      end

      // Response backpressure: everything holds, a new request is refused.
      if1.rsp_ready_i = 1'b0;
      run_op(1, 2'd0, 16'h1234, 16'h0101, 4'b0000, r, fl, lat, p);
      check("bp_result", 32'(r), 32'h1335);
      check("bp_latency", 32'(lat), 32'd5);
      drive_req(1, 1'b1, 2'd1, 16'h7777, 16'h0000, 4'b1111);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); snap(1);
         check("bp_rsp_valid", 32'(s_rsp_valid), 32'd1);
         check("bp_rsp_result", 32'(s_rsp_result), 32'h1335);
         check("bp_rsp_flags", 32'(s_rsp_flags), 32'h0);
         check("bp_req_ready", 32'(s_req_ready), 32'd0);
         check("bp_alu_valid", 32'(s_alu_valid), 32'd0);
         @(posedge clk); #1;
      end
      drive_req(1, 1'b0, 2'd0, 16'h0, 16'h0, 4'h0);
      if1.rsp_ready_i = 1'b1;
      @(negedge clk); snap(1);
      check("bp_release_valid", 32'(s_rsp_valid), 32'd1);
      @(posedge clk); #1;
      @(negedge clk); snap(1);
      check("post_hs_req_ready", 32'(s_req_ready), 32'd1);
      check("post_hs_rsp_valid", 32'(s_rsp_valid), 32'd0);
      @(posedge clk); #1;

      // Async reset during HI_WAIT; the high result arriving afterwards must be ignored.
      drive_req(1, 1'b1, 2'd0, 16'h00FF, 16'h0001, 4'b1000);
      @(negedge clk); snap(1);
      check("rst_seq_ready", 32'(s_req_ready), 32'd1);
      @(posedge clk); #1;
      drive_req(1, 1'b0, 2'd0, 16'h0, 16'h0, 4'h0);
      repeat (2) @(posedge clk);
      @(negedge clk); snap(1);
      check("rst_seq_hi_issue", 32'(s_alu_valid), 32'd1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1; snap(1);
      check("midrst_req_ready", 32'(s_req_ready), 32'd1);
      check("midrst_alu_valid", 32'(s_alu_valid), 32'd0);
      check("midrst_alu_sub", 32'(s_alu_sub), 32'd0);
      check("midrst_alu_cin", 32'(s_alu_cin), 32'd0);
      check("midrst_alu_a", 32'(s_alu_a), 32'd0);
      check("midrst_alu_b", 32'(s_alu_b), 32'd0);
      check("midrst_rsp_valid", 32'(s_rsp_valid), 32'd0);
      check("midrst_rsp_result", 32'(s_rsp_result), 32'd0);
      check("midrst_rsp_flags", 32'(s_rsp_flags), 32'd0);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         @(negedge clk); snap(1);
         check("late_rsp_valid", 32'(s_rsp_valid), 32'd0);
         check("late_req_ready", 32'(s_req_ready), 32'd1);
         check("late_rsp_result", 32'(s_rsp_result), 32'd0);
      end
      @(posedge clk); #1;

      for (int i = 0; i < 3; i++) begin
         run_op(1, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].f, r, fl, lat, p);
         check("perf_op_result", 32'(r), 32'(vecs[i].exp_r));
      end
`ifdef ALU_SEQ_PERF_CNT_EN
      check("perf_count", 32'(perf1), 32'd3);
`endif

      run_op(3, 2'd0, 16'h1234, 16'h4321, 4'b0000, r, fl, lat, p);
      check("l3_result", 32'(r), 32'h5555);
      check("l3_flags", 32'(fl), 32'h0);
      check("l3_latency", 32'(lat), 32'd9);
      check("l3_pulses", 32'(p), 32'd2);

      for (int k = 0; k < 60; k++) rand_op(1, 3 + 2 * L1);
      for (int k = 0; k < 25; k++) rand_op(3, 3 + 2 * L3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu16_sequencer.md
Name: alu16_sequencer

Overview:
- Sequences 16-bit CPU arithmetic (ADD HL,rr / INC rr / DEC rr / ADD SP,e8) onto the 8-bit registered ALU as two chained byte operations.
- Low byte first; its carry/borrow is chained into the high-byte op.
- Sits between the instruction decoder/microcode (request side) and the ALU.
- Produces the 16-bit result plus Game Boy ZNHC flags.

Parameters:
- ALU_LATENCY, 1, cycles from an ALU issue cycle to the cycle `alu_result_i`/`alu_cout_i`/`alu_hout_i` are valid. Legal range 1..4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_cmd_i  in  2  00 ADD16, 01 INC16, 10 DEC16, 11 ADD_SP_E8
- req_a_i  in  16  operand A (HL / rr / SP)
- req_b_i  in  16  operand B (rr; for ADD_SP_E8 only [7:0] is used, signed)
- req_flags_i  in  4  current F as {Z,N,H,C}
- alu_valid_o  out  1  one-cycle ALU issue strobe
- alu_sub_o  out  1  0 add, 1 subtract
- alu_cin_o  out  1  carry-in (add) / borrow-in (sub)
- alu_a_o  out  8  ALU operand A
- alu_b_o  out  8  ALU operand B
- alu_result_i  in  8  ALU result
- alu_cout_i  in  1  carry out of bit 7 / borrow
- alu_hout_i  in  1  carry out of bit 3 / half-borrow
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_result_o  out  16  16-bit result
- rsp_flags_o  out  4  new F {Z,N,H,C}

Behaviour:
- Reset (async, any state): state IDLE.
  - req_ready_o=1.
  - alu_valid_o, alu_sub_o, alu_cin_o, alu_a_o, alu_b_o = 0.
  - rsp_valid_o=0, rsp_result_o=0, rsp_flags_o=0.
  - Reset mid-operation abandons the op; any late ALU result is ignored.
- States and transitions:
  - IDLE -> LO_ISSUE on accept.
  - LO_ISSUE -> LO_WAIT.
  - LO_WAIT -> HI_ISSUE after ALU_LATENCY-1 further cycles. The low result is sampled ALU_LATENCY cycles after LO_ISSUE.
  - HI_ISSUE -> HI_WAIT.
  - HI_WAIT -> RESP once the high result is sampled.
  - RESP -> IDLE on rsp_ready_i.
- req_ready_o is high only in IDLE. Request fields are registered at accept; later input changes are ignored.
- Sampled carry/half-carry are registered; the high op never uses the ALU outputs combinationally.
- alu_valid_o is high exactly in LO_ISSUE and HI_ISSUE. ALU operand outputs are meaningful only then and are don't-care otherwise. ALU inputs are ignored outside sample cycles.
- Byte ops per command (LO op / HI op):
  - ADD16: a_lo+b_lo, cin=0 / a_hi+b_hi, cin=c_lo.
  - INC16: a_lo+1, cin=0 / a_hi+0, cin=c_lo.
  - DEC16: a_lo-1, sub, bin=0 / a_hi-0, sub, bin=borrow_lo.
  - ADD_SP_E8: a_lo+b[7:0], cin=0 / a_hi+{8{b[7]}}, cin=c_lo.
- Flags:
  - ADD16: Z=req Z, N=0, H=hout of HI op (bit 11), C=cout of HI op (bit 15).
  - INC16/DEC16: all flags = req_flags_i, unchanged.
  - ADD_SP_E8: Z=0, N=0, H=hout of LO op, C=cout of LO op.
- Latency: accept at cycle 0 -> rsp_valid_o at cycle 3+2*ALU_LATENCY (5 for default).
- RESP backpressure: rsp_valid_o, rsp_result_o, rsp_flags_o hold stable until rsp_ready_i. No new request is accepted while not in IDLE.
- After the response handshake, req_ready_o is high the next cycle. Minimum issue interval is 4+2*ALU_LATENCY cycles.

Optional Feature:
- Macro ALU_SEQ_PERF_CNT_EN.
- Defined: adds port perf_count_o, out, 16 bits.
  - Counts completed response handshakes.
  - Resets to 0 and saturates at 0xFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- ADD16 a=0x0FFF b=0x0001 flags=1000 -> result 0x1000, flags Z1 N0 H1 C0. rsp_valid_o exactly 5 cycles after accept; two alu_valid_o pulses (ADD cin0, then ADD cin1).
- ADD16 a=0xFFFF b=0x0001 flags=0000 -> 0x0000, flags 0011 (Z not set by result).
- INC16 0xFFFF flags=1010 -> 0x0000 flags 1010. DEC16 0x0000 flags=0101 -> 0xFFFF flags 0101; HI op has alu_sub_o=1, alu_cin_o=1.
- ADD_SP_E8 a=0xFFF8 b=0x0008 -> 0x0000 flags 0011. ADD_SP_E8 a=0x1000 b=0x00FF -> 0x0FFF flags 0000, HI alu_b_o=0xFF.
- rsp_ready_i low 4 cycles -> outputs stable, req_ready_o low, no ALU issue. Then async reset asserted during HI_WAIT -> immediate IDLE with all outputs 0, and a late ALU result is ignored.
- ALU_LATENCY=3, ADD16 0x1234+0x4321 -> 0x5555 flags 0000, rsp_valid_o at cycle 9. With ALU_SEQ_PERF_CNT_EN: after 3 completed ops perf_count_o=3.
